// File: rtl/mrd_sched_pkg.sv
// mrd_sched_pkg: state type, DFT size table and
// size-to-beat helper for the mrd frame scheduler.
package mrd_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    FEED,
    DRAIN,
    GAP
  } sched_state_t;

  localparam int NUM_SIZES = 34;
  localparam int SIZE_W    = 6;
  localparam int BEAT_W    = 9;

  localparam int unsigned POINTS [NUM_SIZES] = '{
    12, 24, 36, 48, 60, 72, 96, 108, 120, 144,
    180, 192, 216, 240, 288, 300, 324, 360, 384, 432,
    480, 540, 576, 600, 648, 720, 768, 864, 900, 960,
    972, 1080, 1152, 1200
  };

  // 4 samples per beat; 0 flags an unsupported size
  function automatic logic [BEAT_W-1:0] size_to_beats(
    input logic [SIZE_W-1:0] idx
  );
    logic [BEAT_W-1:0] b;
    b = '0;
    for (int i = 0; i < NUM_SIZES; i++) begin
      if (idx == SIZE_W'(i)) b = BEAT_W'(POINTS[i] / 4);
    end
    return b;
  endfunction

endpackage

// File: rtl/mrd_sched_beat_cnt.sv
// mrd_sched_beat_cnt: loadable down-counter of frame
// beats with first/last beat flags.
module mrd_sched_beat_cnt
  import mrd_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [BEAT_W-1:0] load_val,
  input  logic              dec,
  output logic              first,
  output logic              last
);

  logic [BEAT_W-1:0] total;
  logic [BEAT_W-1:0] rem;

  // remaining beats; total kept to spot beat 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total <= '0;
      rem   <= '0;
    end else if (load) begin
      total <= load_val;
      rem   <= load_val;
    end else if (dec && rem != '0) begin
      rem <= rem - BEAT_W'(1);
    end
  end

  assign first = (rem == total) && (rem != '0);
  assign last  = (rem == BEAT_W'(1));

endmodule

// File: rtl/mrd_frame_sched_p4.sv
// mrd_frame_sched_p4: job scheduler and sink framing for
// the 4-sample/cycle DFT core. Option: MRD_SCHED_WDOG_EN.
module mrd_frame_sched_p4
  import mrd_sched_pkg::*;
#(
  parameter int GAP_CYCLES  = 8,
  parameter int WDOG_CYCLES = 65535,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_size,
  input  logic             req_inverse,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             core_sink_valid,
  output logic             core_sink_sop,
  output logic             core_sink_eop,
  input  logic             core_sink_ready,
  output logic [5:0]       core_size,
  output logic             core_inverse,
  input  logic             core_source_eop,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             err_size,
  output logic             err_timeout
);

  if (GAP_CYCLES < 1 || WDOG_CYCLES < 1 ||
      WDOG_CYCLES > 65535) begin : g_bad_cfg
    $error("mrd_frame_sched_p4: bad parameters");
  end

  sched_state_t state, state_nx;

  logic [BEAT_W-1:0] beats_ld;
  logic              idle;
  logic              acc_ok;
  logic              acc_bad;
  logic              xfer;
  logic              first;
  logic              last;
  logic              src_done;
  logic              gap_done;
  logic              wd_fire;
  logic [15:0]       gap_cnt;

  assign beats_ld = size_to_beats(req_size);
  assign idle     = (state == IDLE);
  assign acc_ok   = idle & rst_n & req_valid &
                    (beats_ld != '0);
  assign acc_bad  = idle & rst_n & req_valid &
                    (beats_ld == '0);
  assign xfer     = (state == FEED) & in_valid &
                    core_sink_ready;
  assign src_done = (state == DRAIN) & core_source_eop;
  assign gap_done = (gap_cnt == 16'(GAP_CYCLES - 1));

  mrd_sched_beat_cnt u_beat_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (acc_ok),
    .load_val (beats_ld),
    .dec      (xfer),
    .first    (first),
    .last     (last)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next state and combinational handshake/framing
  always_comb begin
    state_nx        = state;
    req_ready       = 1'b0;
    in_ready        = 1'b0;
    core_sink_valid = 1'b0;
    core_sink_sop   = 1'b0;
    core_sink_eop   = 1'b0;
    busy            = 1'b1;
    unique case (state)
      IDLE: begin
        req_ready = rst_n;
        busy      = 1'b0;
        if (acc_ok) state_nx = CFG;
      end
      CFG: state_nx = FEED;
      FEED: begin
        in_ready        = core_sink_ready;
        core_sink_valid = xfer;
        core_sink_sop   = xfer & first;
        core_sink_eop   = xfer & last;
        if (xfer && last) state_nx = DRAIN;
      end
      DRAIN: begin
        if (src_done || wd_fire) state_nx = GAP;
      end
      GAP: begin
        if (gap_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // GAP dwell counter, cleared outside GAP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             gap_cnt <= '0;
    else if (state != GAP)  gap_cnt <= '0;
    else                    gap_cnt <= gap_cnt + 16'd1;
  end

  // core config held from accept until next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_size    <= '0;
      core_inverse <= 1'b0;
    end else if (acc_ok) begin
      core_size    <= req_size;
      core_inverse <= req_inverse;
    end
  end

  // completed frames and size-error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      err_size  <= 1'b0;
    end else begin
      err_size <= acc_bad;
      if (src_done) frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

`ifdef MRD_SCHED_WDOG_EN
  logic [15:0] wd_cnt;

  assign wd_fire = (state == DRAIN) & ~core_source_eop &
                   (wd_cnt == 16'(WDOG_CYCLES - 1));

  // drain watchdog, cleared outside DRAIN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= wd_fire;
      if (state != DRAIN) wd_cnt <= '0;
      else                wd_cnt <= wd_cnt + 16'd1;
    end
  end
`else
  assign wd_fire     = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule
